// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared main_memory port.
// slave = arbiter side, master = requesters plus memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] req0_addr;
    logic              req0_write_en;
    logic [DATA_W-1:0] req0_write_data;
    logic              req0_read_addr_valid;
    logic              req0_read_ready;
    logic [DATA_W-1:0] req0_read_data;
    logic              req0_read_valid;
    logic              req0_grant;

    logic [ADDR_W-1:0] req1_addr;
    logic              req1_write_en;
    logic [DATA_W-1:0] req1_write_data;
    logic              req1_read_addr_valid;
    logic              req1_read_ready;
    logic [DATA_W-1:0] req1_read_data;
    logic              req1_read_valid;
    logic              req1_grant;

    logic [ADDR_W-1:0] memory_addr;
    logic              memory_write_en;
    logic [DATA_W-1:0] memory_write_data;
    logic              memory_read_addr_valid;
    logic              memory_read_ready;
    logic [DATA_W-1:0] memory_read_data;
    logic              memory_read_valid;

    modport slave (
        input  req0_addr, req0_write_en, req0_write_data, req0_read_addr_valid,
        input  req1_addr, req1_write_en, req1_write_data, req1_read_addr_valid,
        output req0_read_ready, req0_read_data, req0_read_valid, req0_grant,
        output req1_read_ready, req1_read_data, req1_read_valid, req1_grant,
        output memory_addr, memory_write_en, memory_write_data, memory_read_addr_valid,
        input  memory_read_ready, memory_read_data, memory_read_valid
    );

    modport master (
        output req0_addr, req0_write_en, req0_write_data, req0_read_addr_valid,
        output req1_addr, req1_write_en, req1_write_data, req1_read_addr_valid,
        input  req0_read_ready, req0_read_data, req0_read_valid, req0_grant,
        input  req1_read_ready, req1_read_data, req1_read_valid, req1_grant,
        input  memory_addr, memory_write_en, memory_write_data, memory_read_addr_valid,
        output memory_read_ready, memory_read_data, memory_read_valid
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single main_memory port: one write or one BURST_LEN refill per grant.
// Define ARB_FIXED_PRIORITY_EN to make requester 0 win every tie instead of round-robin.
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 8
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
    output logic                arb_busy,
    output logic                arb_owner
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE      = 2'd1,
        READ_BURST = 2'd2
    } state_t;

    localparam logic [7:0] BURST_CNT = 8'(BURST_LEN);
    localparam logic [7:0] LAST_RESP = 8'(BURST_LEN - 1);

    state_t      state, state_nxt;
    logic        owner, owner_nxt;
    logic        last, last_nxt;
    logic [7:0]  addr_cnt, addr_cnt_nxt;
    logic [7:0]  resp_cnt, resp_cnt_nxt;

    logic              req0, req1, sel, sel_we;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;
    logic              own_rav, addr_ok, addr_fire;

    assign req0 = bus.req0_write_en | bus.req0_read_addr_valid;
    assign req1 = bus.req1_write_en | bus.req1_read_addr_valid;

`ifdef ARB_FIXED_PRIORITY_EN
    assign sel = ~req0;
`else
    // On a tie the requester that did not win last time goes next.
    assign sel = (req0 & req1) ? ~last : req1;
`endif

    assign sel_we    = sel ? bus.req1_write_en : bus.req0_write_en;
    assign own_addr  = owner ? bus.req1_addr : bus.req0_addr;
    assign own_wdata = owner ? bus.req1_write_data : bus.req0_write_data;
    assign own_rav   = owner ? bus.req1_read_addr_valid : bus.req0_read_addr_valid;
    assign addr_ok   = addr_cnt < BURST_CNT;
    assign addr_fire = own_rav & addr_ok & bus.memory_read_ready;

    assign bus.req0_read_data = bus.memory_read_data;
    assign bus.req1_read_data = bus.memory_read_data;

    assign arb_busy  = state != IDLE;
    assign arb_owner = owner;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last     <= 1'b1;
            addr_cnt <= 8'd0;
            resp_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            last     <= last_nxt;
            addr_cnt <= addr_cnt_nxt;
            resp_cnt <= resp_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        last_nxt     = last;
        addr_cnt_nxt = addr_cnt;
        resp_cnt_nxt = resp_cnt;

        bus.req0_grant             = 1'b0;
        bus.req1_grant             = 1'b0;
        bus.req0_read_ready        = 1'b0;
        bus.req1_read_ready        = 1'b0;
        bus.req0_read_valid        = 1'b0;
        bus.req1_read_valid        = 1'b0;
        bus.memory_addr            = '0;
        bus.memory_write_en        = 1'b0;
        bus.memory_write_data      = '0;
        bus.memory_read_addr_valid = 1'b0;

        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    owner_nxt    = sel;
                    addr_cnt_nxt = 8'd0;
                    resp_cnt_nxt = 8'd0;
                    state_nxt    = sel_we ? WRITE : READ_BURST;
                end
            end

            WRITE: begin
                bus.req0_grant        = ~owner;
                bus.req1_grant        = owner;
                bus.memory_addr       = own_addr;
                bus.memory_write_en   = 1'b1;
                bus.memory_write_data = own_wdata;
                last_nxt              = owner;
                state_nxt             = IDLE;
            end

            READ_BURST: begin
                bus.req0_grant             = ~owner;
                bus.req1_grant             = owner;
                bus.memory_addr            = own_addr;
                // Addresses beyond the burst length are swallowed here.
                bus.memory_read_addr_valid = own_rav & addr_ok;
                bus.req0_read_ready        = ~owner & bus.memory_read_ready;
                bus.req1_read_ready        = owner & bus.memory_read_ready;
                bus.req0_read_valid        = ~owner & bus.memory_read_valid;
                bus.req1_read_valid        = owner & bus.memory_read_valid;
                if (addr_fire) begin
                    addr_cnt_nxt = addr_cnt + 8'd1;
                end
                if (bus.memory_read_valid) begin
                    resp_cnt_nxt = resp_cnt + 8'd1;
                    if (resp_cnt == LAST_RESP) begin
                        last_nxt  = owner;
                        state_nxt = IDLE;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int BURST_LEN = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    logic arb_busy, arb_owner;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .arb_busy  (arb_busy),
        .arb_owner (arb_owner)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level model: is a grant open, who holds it, what kind, how far along.
    bit m_busy = 0, m_own = 0, m_wr = 0, m_last = 1;
    int m_iss = 0, m_rsp = 0;

    // Memory responder and observation state.
    int mem_mode = 0;   // 0 = bench responder answers accepted addresses, else inputs driven by the test
    bit resp_en  = 0;
    int pending  = 0;
    int resp_idx = 0;
    bit prev_g0 = 0, prev_g1 = 0;
    int order[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.req0_addr = '0; bus.req0_write_en = 0; bus.req0_write_data = '0; bus.req0_read_addr_valid = 0;
        bus.req1_addr = '0; bus.req1_write_en = 0; bus.req1_write_data = '0; bus.req1_read_addr_valid = 0;
        bus.memory_read_ready = 0; bus.memory_read_data = '0; bus.memory_read_valid = 0;
    endtask

    task automatic compare_all();
        logic [ADDR_W-1:0] oa;
        logic [DATA_W-1:0] ow;
        logic orav, rd;
        oa   = m_own ? bus.req1_addr : bus.req0_addr;
        ow   = m_own ? bus.req1_write_data : bus.req0_write_data;
        orav = m_own ? bus.req1_read_addr_valid : bus.req0_read_addr_valid;
        rd   = m_busy && !m_wr;
        check("busy",      64'(arb_busy),               64'(m_busy));
        check("owner",     64'(arb_owner),              64'(m_own));
        check("grant0",    64'(bus.req0_grant),         64'(m_busy && !m_own));
        check("grant1",    64'(bus.req1_grant),         64'(m_busy && m_own));
        check("mem_addr",  64'(bus.memory_addr),        m_busy ? 64'(oa) : 64'd0);
        check("mem_we",    64'(bus.memory_write_en),    64'(m_busy && m_wr));
        check("mem_wdata", 64'(bus.memory_write_data),  (m_busy && m_wr) ? 64'(ow) : 64'd0);
        check("mem_rav",   64'(bus.memory_read_addr_valid), 64'(rd && orav && (m_iss < BURST_LEN)));
        check("rrdy0",     64'(bus.req0_read_ready),    64'(rd && !m_own && bus.memory_read_ready));
        check("rrdy1",     64'(bus.req1_read_ready),    64'(rd && m_own && bus.memory_read_ready));
        check("rvld0",     64'(bus.req0_read_valid),    64'(rd && !m_own && bus.memory_read_valid));
        check("rvld1",     64'(bus.req1_read_valid),    64'(rd && m_own && bus.memory_read_valid));
        check("rdata0",    64'(bus.req0_read_data),     64'(bus.memory_read_data));
        check("rdata1",    64'(bus.req1_read_data),     64'(bus.memory_read_data));
    endtask

    task automatic model_update();
        bit r0, r1, s, orav;
        if (!rst) return;
        if (!m_busy) begin
            r0 = bus.req0_write_en || bus.req0_read_addr_valid;
            r1 = bus.req1_write_en || bus.req1_read_addr_valid;
            if (r0 || r1) begin
                if (r0 && r1) begin
`ifdef ARB_FIXED_PRIORITY_EN
                    s = 0;
`else
                    s = (m_last == 0);
`endif
                end else begin
                    s = r1;
                end
                m_busy = 1;
                m_own  = s;
                m_wr   = s ? bus.req1_write_en : bus.req0_write_en;
                m_iss  = 0;
                m_rsp  = 0;
            end
        end else if (m_wr) begin
            m_busy = 0;
            m_last = m_own;
        end else begin
            orav = m_own ? bus.req1_read_addr_valid : bus.req0_read_addr_valid;
            if (orav && m_iss < BURST_LEN && bus.memory_read_ready) m_iss++;
            if (bus.memory_read_valid) begin
                m_rsp++;
                if (m_rsp == BURST_LEN) begin
                    m_busy = 0;
                    m_last = m_own;
                end
            end
        end
    endtask

    task automatic tick_check();
        @(negedge clk);
        compare_all();
        if (bus.req0_grant && !prev_g0) order.push_back(0);
        if (bus.req1_grant && !prev_g1) order.push_back(1);
        prev_g0 = bus.req0_grant;
        prev_g1 = bus.req1_grant;
        if (mem_mode == 0) begin
            if (bus.memory_read_addr_valid && bus.memory_read_ready) pending++;
            if (bus.memory_read_valid) begin
                pending--;
                resp_idx++;
            end
        end
    endtask

    task automatic tick_adv();
        @(posedge clk);
        model_update();
        #1;
        if (mem_mode == 0) begin
            bus.memory_read_valid = resp_en && (pending > 0);
            bus.memory_read_data  = DATA_W'(resp_idx);
        end
    endtask

    task automatic cyc();
        tick_check();
        tick_adv();
    endtask

    task automatic do_reset();
        rst = 0;
        idle_inputs();
        #1;
        check("rst_busy",  64'(arb_busy), 64'd0);
        check("rst_owner", 64'(arb_owner), 64'd0);
        check("rst_g0",    64'(bus.req0_grant), 64'd0);
        check("rst_g1",    64'(bus.req1_grant), 64'd0);
        check("rst_we",    64'(bus.memory_write_en), 64'd0);
        check("rst_rav",   64'(bus.memory_read_addr_valid), 64'd0);
        check("rst_addr",  64'(bus.memory_addr), 64'd0);
        check("rst_rv",    64'({bus.req0_read_valid, bus.req1_read_valid}), 64'd0);
        m_busy = 0; m_own = 0; m_wr = 0; m_last = 1; m_iss = 0; m_rsp = 0;
        pending = 0; resp_en = 0;
        repeat (2) cyc();
        rst = 1;
    endtask

    task automatic set_req_read(input bit who, input bit rav, input logic [ADDR_W-1:0] a);
        bus.req0_read_addr_valid = !who && rav;
        bus.req1_read_addr_valid = who && rav;
        bus.req0_addr = who ? '0 : a;
        bus.req1_addr = who ? a : '0;
    endtask

    // Owner holds read_addr_valid for `hold` granted cycles; memory answers once issuing stops.
    task automatic burst(input bit who, input int hold, input int stop_rsp,
                         output int n_mrav, output int n_own, output int n_oth);
        int acc;
        acc = 0; n_mrav = 0; n_own = 0; n_oth = 0;
        resp_idx = 0; mem_mode = 0; resp_en = 0;
        bus.memory_read_ready = 1;
        for (int c = 0; c < 120; c++) begin
            set_req_read(who, acc < hold, ADDR_W'(32'h100 + 4 * acc));
            tick_check();
            if (bus.memory_read_addr_valid) n_mrav++;
            if (who ? bus.req1_grant : bus.req0_grant) acc++;
            if (who ? bus.req1_read_valid : bus.req0_read_valid) begin
                check("burst_data", 64'(who ? bus.req1_read_data : bus.req0_read_data), 64'(n_own));
                n_own++;
            end
            if (who ? bus.req0_read_valid : bus.req1_read_valid) n_oth++;
            resp_en = (acc >= hold);
            if (n_own == stop_rsp) break;
            tick_adv();
        end
    endtask

    initial begin
        int n_mrav, n_own, n_oth, late_rv;
        idle_inputs();
        #2;
        do_reset();

        // Single write from reset.
        bus.req0_write_en = 1; bus.req0_addr = 32'h40; bus.req0_write_data = 32'hDEADBEEF;
        tick_check();
        check("wr_c0_grant", 64'(bus.req0_grant), 64'd0);
        tick_adv();
        tick_check();
        check("wr_grant", 64'(bus.req0_grant), 64'd1);
        check("wr_we",    64'(bus.memory_write_en), 64'd1);
        check("wr_addr",  64'(bus.memory_addr), 64'h40);
        check("wr_data",  64'(bus.memory_write_data), 64'hDEADBEEF);
        bus.req0_write_en = 0;
        tick_adv();
        tick_check();
        check("wr_idle", 64'(arb_busy), 64'd0);
        tick_adv();

        // Refill burst by requester 1.
        burst(1'b1, 8, 8, n_mrav, n_own, n_oth);
        tick_adv();
        idle_inputs();
        tick_check();
        check("rf_grant_drop", 64'(bus.req1_grant), 64'd0);
        check("rf_strobes",    64'(n_own), 64'd8);
        check("rf_other",      64'(n_oth), 64'd0);
        check("rf_addrs",      64'(n_mrav), 64'd8);
        tick_adv();

        // Over-issue: 12 cycles of valid addresses, only 8 reach memory.
        burst(1'b0, 12, 8, n_mrav, n_own, n_oth);
        tick_adv();
        idle_inputs();
        tick_check();
        check("ov_addrs",   64'(n_mrav), 64'd8);
        check("ov_strobes", 64'(n_own), 64'd8);
        check("ov_drop",    64'(bus.req0_grant), 64'd0);
        tick_adv();

        // Write takes precedence over read from the same requester.
        bus.req0_write_en = 1; bus.req0_read_addr_valid = 1;
        bus.req0_addr = 32'h200; bus.req0_write_data = 32'h12345678;
        tick_adv();
        tick_check();
        check("wbr_we",  64'(bus.memory_write_en), 64'd1);
        check("wbr_rav", 64'(bus.memory_read_addr_valid), 64'd0);
        bus.req0_write_en = 0; bus.req0_read_addr_valid = 0;
        tick_adv();
        tick_check();
        check("wbr_idle", 64'(arb_busy), 64'd0);
        tick_adv();

        // Contention from reset: both requesters read continuously.
        do_reset();
        order.delete();
        mem_mode = 0; resp_en = 1; resp_idx = 0;
        bus.memory_read_ready = 1;
        bus.req0_read_addr_valid = 1; bus.req1_read_addr_valid = 1;
        bus.req0_addr = 32'h1000; bus.req1_addr = 32'h2000;
        for (int c = 0; c < 300; c++) begin
            tick_check();
            if (order.size() >= 4 && !arb_busy) begin
                bus.req0_read_addr_valid = 0; bus.req1_read_addr_valid = 0;
                tick_adv();
                break;
            end
            tick_adv();
        end
        check("ct_grants", 64'(order.size()), 64'd4);
        for (int i = 0; i < 4 && i < order.size(); i++) begin
`ifdef ARB_FIXED_PRIORITY_EN
            check("ct_order", 64'(order[i]), 64'd0);
`else
            check("ct_order", 64'(order[i]), 64'(i % 2));
`endif
        end

        // Reset in the middle of a burst; late responses must be dropped.
        burst(1'b0, 8, 3, n_mrav, n_own, n_oth);
        check("mr_rsp3", 64'(n_own), 64'd3);
        do_reset();
        mem_mode = 1;
        late_rv = 0;
        bus.memory_read_valid = 1; bus.memory_read_data = 32'h55;
        repeat (2) begin
            tick_check();
            if (bus.req0_read_valid || bus.req1_read_valid) late_rv++;
            tick_adv();
        end
        check("mr_late_rv", 64'(late_rv), 64'd0);
        bus.memory_read_valid = 0;
        bus.req0_write_en = 1; bus.req0_addr = 32'h80; bus.req0_write_data = 32'hCAFE;
        tick_check();
        tick_adv();
        tick_check();
        check("mr_wr_grant", 64'(bus.req0_grant), 64'd1);
        check("mr_wr_we",    64'(bus.memory_write_en), 64'd1);
        bus.req0_write_en = 0;
        tick_adv();

        // Randomized traffic including stray responses and a mid-run reset.
        mem_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            bus.req0_write_en        = ($urandom_range(0, 3) == 0);
            bus.req0_read_addr_valid = 1'($urandom_range(0, 1));
            bus.req0_addr            = $urandom;
            bus.req0_write_data      = $urandom;
            bus.req1_write_en        = ($urandom_range(0, 3) == 0);
            bus.req1_read_addr_valid = 1'($urandom_range(0, 1));
            bus.req1_addr            = $urandom;
            bus.req1_write_data      = $urandom;
            bus.memory_read_ready    = 1'($urandom_range(0, 1));
            bus.memory_read_valid    = ($urandom_range(0, 2) != 0);
            bus.memory_read_data     = $urandom;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single `main_memory` port between two cache controllers, or a cache controller and a write path. It sits between the requesters' memory-side buses and `main_memory`. It grants the port for one atomic transaction: either a single-word write or a refill burst of `BURST_LEN` reads. Routing of address, data and handshakes is combinational while a grant is held.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data word width.
- `BURST_LEN`, 8, read responses per refill burst (256-bit line / 32-bit word); legal range 1..255.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `reqN_addr`  in  ADDR_W  requester N (N=0,1) address.
- `reqN_write_en`  in  1  write request; held until granted.
- `reqN_write_data`  in  DATA_W  write data.
- `reqN_read_addr_valid`  in  1  read address valid.
- `reqN_read_ready`  out  1  memory accepted read address (forwarded `memory_read_ready`, owner only).
- `reqN_read_data`  out  DATA_W  read data (`memory_read_data`, broadcast).
- `reqN_read_valid`  out  1  read response strobe, owner only.
- `reqN_grant`  out  1  requester N owns the port.
- `memory_addr`  out  ADDR_W  to `main_memory` read/write address.
- `memory_write_en`, `memory_write_data`  out  1/DATA_W  write channel.
- `memory_read_addr_valid`  out  1  read address valid.
- `memory_read_ready`  in  1  memory can accept read address.
- `memory_read_data`, `memory_read_valid`  in  DATA_W/1  read response.
- `arb_busy`  out  1  state != IDLE.
- `arb_owner`  out  1  current or last owner index.

## Operation
- Request N = `reqN_write_en | reqN_read_addr_valid`. If both are set, the write takes precedence.
- FSM states are IDLE, WRITE and READ_BURST, plus an `owner` register, a `last` round-robin pointer, `addr_cnt` and `resp_cnt` (each 8 bits).
- **IDLE**
  - No request: stay in IDLE.
  - One requester: select it.
  - Both requesters: select `!last`.
  - Register `owner`. Go to WRITE if the selected request is a write, otherwise go to READ_BURST. Clear both counters.
- **WRITE**
  - `reqN_grant` = 1 for the owner.
  - Drive `memory_addr`, `memory_write_en` and `memory_write_data` from the owner for exactly one cycle.
  - Set `last` = owner. Return to IDLE.
- **READ_BURST**
  - `reqN_grant` = 1 for the owner.
  - `memory_addr` = owner addr.
  - `memory_read_addr_valid` = owner `read_addr_valid` AND `addr_cnt < BURST_LEN`.
  - `addr_cnt` increments on each cycle where `memory_read_addr_valid & memory_read_ready`.
  - `resp_cnt` increments on each `memory_read_valid`. That strobe is forwarded only to the owner.
  - When a response arrives with `resp_cnt == BURST_LEN-1`, set `last` = owner and return to IDLE.
- Non-owner outputs are 0: `read_ready`, `read_valid` and `grant`. `read_data` is not gated.
- When the port is idle, memory outputs are 0.
- A `memory_read_valid` in IDLE or WRITE (stray) is dropped and not counted.
- An owner that deasserts `read_addr_valid` mid-burst keeps the grant until `BURST_LEN` responses arrive. There is no timeout.
- Address requests beyond `BURST_LEN` are masked and never reach memory.
- Reset: all outputs 0; state IDLE; counters 0; `last` = 1, so requester 0 wins the first tie. Reset mid-burst abandons the burst. Late responses that arrive after reset are dropped as stray.

## Timing
- Grant latency is 1 cycle from request in IDLE.
- Write: `memory_write_en` is high in the cycle after the request is sampled. The arbiter is back in IDLE the cycle after that, so back-to-back writes from one requester take 2 cycles each.
- Read: first `memory_read_addr_valid` is 1 cycle after the request. IDLE is re-entered on the cycle after the `BURST_LEN`-th response.
- All forwarding inside a grant is combinational with zero added latency.
- Under contention, grants alternate strictly between requesters in both read and write mixes.

## Configuration
- `ARB_FIXED_PRIORITY_EN`
  - Defined: in IDLE, requester 0 always wins ties, and `last` is ignored.
  - Undefined (default): round-robin as specified above.

## Test plan
- Single write: `req0_write_en`, addr 0x40, data 0xDEADBEEF, from reset. Required response: `req0_grant` and `memory_write_en` high together in cycle 1 with addr 0x40 and data 0xDEADBEEF; `arb_busy` low in cycle 2.
- Refill burst: req1 issues 8 reads at 0x100..0x11C, memory answers with 0..7. Required response: `req1_read_valid` pulses exactly 8 times with data 0..7; `req1_grant` drops the cycle after the 8th response; `req0` gets no strobes.
- Contention: both requesters read continuously from reset. Required response: grant order is 0,1,0,1. With `ARB_FIXED_PRIORITY_EN` defined, grant order is 0,0,0.
- Over-issue: the owner holds `read_addr_valid` for 12 accepted cycles. Required response: `memory_read_addr_valid` asserts exactly 8 times, and the extra addresses are masked.
- Reset mid-burst: assert `rst`=0 after 3 responses, then release. Required response: all outputs are 0 immediately; 2 late `memory_read_valid` pulses produce no `reqN_read_valid`; a new req0 write is granted 1 cycle after it is requested.
- Write beats read: req0 asserts both `write_en` and `read_addr_valid` in IDLE. Required response: state goes to WRITE, one `memory_write_en` pulse, and no read address is issued that grant.
